// File: rtl/axi_req_arbiter.sv
// axi_req_arbiter: shares one single-beat AXI3 master between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects alternating arbitration instead of data priority with a starvation guard.
module axi_req_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_valid_f,
  output logic [31:0] inst_rdata_f,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok_m,
  output logic [31:0] data_rdata_m,
  output logic        data_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  localparam logic [2:0] IDLE = 3'd0, RD_AR = 3'd1, RD_R = 3'd2, WR_REQ = 3'd3, WR_B = 3'd4;
  logic [2:0]  state_q, state_d;
  logic        src_q, src_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        inst_valid_q, inst_valid_d, data_ok_q, data_ok_d, err_q, err_d;
  logic        idle, grant, inst_win, wr_st, aw_ok, w_ok, r_fire, b_fire;
  logic        unused_ok;
  assign unused_ok = &{1'b1, rlast};
  assign idle  = state_q == IDLE;
  assign grant = idle & (inst_req | data_req) & !reset;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign inst_win = inst_req & (!data_req | !last_q);
  assign last_d   = grant ? inst_win : last_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= 1'b1;
    else last_q <= last_d;
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_q, starve_d;
  logic          starved;
  assign starved  = starve_q == CW'(STARVE_MAX);
  assign inst_win = inst_req & (!data_req | starved);
  assign starve_d = !idle ? starve_q :
                    (!inst_req | inst_win) ? '0 :
                    (data_req & !starved) ? starve_q + CW'(1) : starve_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_q <= '0;
    else starve_q <= starve_d;
`endif
  assign wr_st  = state_q == WR_REQ;
  assign aw_ok  = aw_done_q | (awvalid & awready);
  assign w_ok   = w_done_q | (wvalid & wready);
  assign r_fire = (state_q == RD_R) & rvalid;
  assign b_fire = (state_q == WR_B) & bvalid;
  always_comb begin
    state_d = idle ? (grant ? ((!inst_win & data_wr) ? WR_REQ : RD_AR) : IDLE) :
              (state_q == RD_AR) ? (arready ? RD_R : RD_AR) :
              (state_q == RD_R) ? (rvalid ? IDLE : RD_R) :
              wr_st ? ((aw_ok & w_ok) ? WR_B : WR_REQ) :
              (state_q == WR_B) ? (bvalid ? IDLE : WR_B) : IDLE;
    src_d        = grant ? inst_win : src_q;
    addr_d       = grant ? (inst_win ? inst_addr : data_addr) : addr_q;
    wdata_d      = grant ? data_wdata : wdata_q;
    wstrb_d      = grant ? data_wstrb : wstrb_q;
    aw_done_d    = wr_st & aw_ok & !w_ok;
    w_done_d     = wr_st & w_ok & !aw_ok;
    inst_valid_d = r_fire & src_q;
    data_ok_d    = (r_fire & !src_q) | b_fire;
    err_d        = (r_fire & !src_q & (rresp != 2'b00)) | (b_fire & (bresp != 2'b00));
    inst_rdata_d = (r_fire & src_q) ? rdata : inst_rdata_q;
    data_rdata_d = (r_fire & !src_q) ? rdata : data_rdata_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      data_ok_q    <= 1'b0;
      err_q        <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      inst_valid_q <= inst_valid_d;
      data_ok_q    <= data_ok_d;
      err_q        <= err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  assign inst_addr_ok   = grant & inst_win;
  assign data_addr_ok   = grant & !inst_win;
  assign inst_valid_f   = inst_valid_q;
  assign inst_rdata_f   = inst_rdata_q;
  assign data_data_ok_m = data_ok_q;
  assign data_rdata_m   = data_rdata_q;
  assign data_err       = err_q;
  assign arid           = src_q ? INST_ID : DATA_ID;
  assign araddr         = addr_q;
  assign arsize         = 3'b010;
  assign arvalid        = state_q == RD_AR;
  assign rready         = state_q == RD_R;
  assign awid           = DATA_ID;
  assign awaddr         = addr_q;
  assign awsize         = 3'b010;
  assign awvalid        = wr_st & !aw_done_q;
  assign wdata          = wdata_q;
  assign wstrb          = wstrb_q;
  assign wlast          = 1'b1;
  assign wvalid         = wr_st & !w_done_q;
  assign bready         = state_q == WR_B;
endmodule

// File: tb/tb_axi_req_arbiter.sv
// tb_axi_req_arbiter: directed scenario checks of axi_req_arbiter against a small reactive AXI slave.
module tb_axi_req_arbiter;
  logic        clk = 0, reset = 1;
  logic        inst_req = 0, data_req = 0, data_wr = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0;
  logic [3:0]  data_wstrb = 0;
  logic        inst_addr_ok, inst_valid_f, data_addr_ok, data_data_ok_m, data_err;
  logic [31:0] inst_rdata_f, data_rdata_m, araddr, awaddr, wdata;
  logic [3:0]  arid, awid, wstrb;
  logic [2:0]  arsize, awsize;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready = 1, awready = 1, wready = 1, r_en = 1;
  logic [31:0] rdata, rd_data_v = 0;
  logic [1:0]  rresp, bresp, rresp_v = 0, bresp_v = 0;
  logic        rvalid, bvalid, r_pend, aw_got, w_got;
  int          checks = 0, fails = 0, aw_hs = 0, w_hs = 0;

  axi_req_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_valid_f(inst_valid_f), .inst_rdata_f(inst_rdata_f),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok_m(data_data_ok_m),
    .data_rdata_m(data_rdata_m), .data_err(data_err),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(1'b1), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) begin
      rvalid <= 0; r_pend <= 0; rdata <= 0; rresp <= 0;
      bvalid <= 0; bresp <= 0; aw_got <= 0; w_got <= 0;
    end else begin
      if (arvalid && arready) r_pend <= 1;
      if (rvalid && rready) rvalid <= 0;
      else if ((r_pend || (arvalid && arready)) && r_en && !rvalid) begin
        rvalid <= 1; rdata <= rd_data_v; rresp <= rresp_v; r_pend <= 0;
      end
      if (awvalid && awready) aw_got <= 1;
      if (wvalid && wready) w_got <= 1;
      if (bvalid && bready) bvalid <= 0;
      else if (aw_got && w_got && !bvalid) begin
        bvalid <= 1; bresp <= bresp_v; aw_got <= 0; w_got <= 0;
      end
    end

  always @(posedge clk) begin
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (wvalid && wready) w_hs <= w_hs + 1;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_valid_f, data_data_ok_m, data_err} !== 10'b0) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=0", {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_valid_f, data_data_ok_m, data_err});
    end
    checks++;
    if (inst_rdata_f !== 32'h0 || data_rdata_m !== 32'h0) begin
      fails++; $display("FAIL reset_rdata got=%h/%h exp=0/0", inst_rdata_f, data_rdata_m);
    end
    checks++;
    if ({arsize, awsize, wlast, awid} !== {3'b010, 3'b010, 1'b1, 4'd1}) begin
      fails++; $display("FAIL reset_const got=%b exp=%b", {arsize, awsize, wlast, awid}, {3'b010, 3'b010, 1'b1, 4'd1});
    end
    reset = 0;
    tick();
  endtask

  task automatic test_fetch();
    rd_data_v = 32'h0280_0000; rresp_v = 0;
    tick(); inst_req = 1; inst_addr = 32'h1C00_0000; #1;
    checks++;
    if (inst_addr_ok !== 1 || data_addr_ok !== 0) begin
      fails++; $display("FAIL fetch_grant got=%b%b exp=10", inst_addr_ok, data_addr_ok);
    end
    tick(); inst_req = 0;
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1C00_0000}) begin
      fails++; $display("FAIL fetch_ar got=%b/%h/%h exp=1/0/1c000000", arvalid, arid, araddr);
    end
    tick();
    checks++;
    if (rready !== 1 || inst_valid_f !== 0) begin
      fails++; $display("FAIL fetch_r got=%b%b exp=10", rready, inst_valid_f);
    end
    tick();
    checks++;
    if (inst_valid_f !== 1 || inst_rdata_f !== 32'h0280_0000 || data_data_ok_m !== 0) begin
      fails++; $display("FAIL fetch_data got=%b/%h/%b exp=1/02800000/0", inst_valid_f, inst_rdata_f, data_data_ok_m);
    end
    tick();
    checks++;
    if (inst_valid_f !== 0) begin
      fails++; $display("FAIL fetch_pulse got=%b exp=0", inst_valid_f);
    end
  endtask

  task automatic test_write();
    int aw0 = aw_hs, w0 = w_hs, n = 0;
    awready = 0; wready = 0; bresp_v = 0;
    tick(); data_req = 1; data_wr = 1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF; #1;
    checks++;
    if (data_addr_ok !== 1 || inst_addr_ok !== 0) begin
      fails++; $display("FAIL wr_grant got=%b%b exp=10", data_addr_ok, inst_addr_ok);
    end
    tick(); data_req = 0; awready = 1;
    checks++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb, awid} !== {2'b11, 32'h100, 32'hDEAD_BEEF, 4'hF, 4'd1}) begin
      fails++; $display("FAIL wr_req got=%b%b/%h/%h/%h/%h", awvalid, wvalid, awaddr, wdata, wstrb, awid);
    end
    tick(); awready = 0;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b010) begin
      fails++; $display("FAIL wr_aw_drop got=%b exp=010", {awvalid, wvalid, bready});
    end
    tick(); wready = 1;
    checks++;
    if ({awvalid, wvalid} !== 2'b01) begin
      fails++; $display("FAIL wr_w_hold got=%b exp=01", {awvalid, wvalid});
    end
    tick(); wready = 0;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      fails++; $display("FAIL wr_b got=%b exp=001", {awvalid, wvalid, bready});
    end
    while (bvalid !== 1 && n < 10) begin tick(); n++; end
    checks++;
    if (bvalid !== 1 || data_data_ok_m !== 0) begin
      fails++; $display("FAIL wr_bvalid got=%b/%b exp=1/0", bvalid, data_data_ok_m);
    end
    tick();
    checks++;
    if (data_data_ok_m !== 1 || data_err !== 0) begin
      fails++; $display("FAIL wr_ok got=%b%b exp=10", data_data_ok_m, data_err);
    end
    tick();
    checks++;
    if (data_data_ok_m !== 0 || aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
      fails++; $display("FAIL wr_once got=%b/%0d/%0d exp=0/1/1", data_data_ok_m, aw_hs - aw0, w_hs - w0);
    end
    awready = 1; wready = 1;
  endtask

  task automatic test_collision();
    int n = 0;
    bit early = 0;
    rd_data_v = 32'h1234_5678;
    tick(); inst_req = 1; inst_addr = 32'h1C00_0004; data_req = 1; data_wr = 0; data_addr = 32'h200; #1;
    checks++;
    if (data_addr_ok !== 1 || inst_addr_ok !== 0) begin
      fails++; $display("FAIL col_first got=%b%b exp=10", data_addr_ok, inst_addr_ok);
    end
    tick(); data_req = 0; #1;
    while (data_data_ok_m !== 1 && n < 20) begin
      if (inst_addr_ok === 1) early = 1;
      tick(); n++;
    end
    checks++;
    if (data_data_ok_m !== 1 || early || inst_addr_ok !== 1 || data_rdata_m !== 32'h1234_5678) begin
      fails++; $display("FAIL col_second got=%b/%b/%b/%h exp=1/0/1/12345678", data_data_ok_m, early, inst_addr_ok, data_rdata_m);
    end
    tick(); inst_req = 0; n = 0;
    while (inst_valid_f !== 1 && n < 20) begin tick(); n++; end
    checks++;
    if (inst_valid_f !== 1 || inst_rdata_f !== 32'h1234_5678) begin
      fails++; $display("FAIL col_inst got=%b/%h exp=1/12345678", inst_valid_f, inst_rdata_f);
    end
  endtask

  task automatic test_starve();
    logic [11:0] seq = 0, exp_seq;
    int g = 0, n = 0;
    bit both = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 12'hAAA;
`else
    exp_seq = 12'h210;
`endif
    rd_data_v = 32'h0000_5555;
    tick(); data_req = 1; data_wr = 0; data_addr = 32'h300; inst_req = 1; inst_addr = 32'h1C00_0010; #1;
    while (g < 12 && n < 100) begin
      if (inst_addr_ok === 1 && data_addr_ok === 1) both = 1;
      if (inst_addr_ok === 1 || data_addr_ok === 1) begin seq[g] = inst_addr_ok; g++; end
      tick(); n++;
    end
    data_req = 0; inst_req = 0;
    checks++;
    if (g != 12 || seq !== exp_seq || both) begin
      fails++; $display("FAIL starve_seq got=%h/%0d/%b exp=%h/12/0", seq, g, both, exp_seq);
    end
    n = 0;
    while (data_data_ok_m !== 1 && inst_valid_f !== 1 && n < 20) begin tick(); n++; end
    checks++;
    if (data_data_ok_m !== 1 && inst_valid_f !== 1) begin
      fails++; $display("FAIL starve_drain got=%b%b exp=done", data_data_ok_m, inst_valid_f);
    end
    tick();
  endtask

  task automatic test_error();
    int n = 0;
    rresp_v = 2'b10; rd_data_v = 32'hBAD0_0000;
    tick(); data_req = 1; data_wr = 0; data_addr = 32'h400; #1;
    tick(); data_req = 0;
    while (data_data_ok_m !== 1 && n < 20) begin tick(); n++; end
    checks++;
    if (data_data_ok_m !== 1 || data_err !== 1 || data_rdata_m !== 32'hBAD0_0000) begin
      fails++; $display("FAIL err_read got=%b%b/%h exp=11/bad00000", data_data_ok_m, data_err, data_rdata_m);
    end
    tick();
    checks++;
    if (data_data_ok_m !== 0 || data_err !== 0) begin
      fails++; $display("FAIL err_pulse got=%b%b exp=00", data_data_ok_m, data_err);
    end
    rresp_v = 0; bresp_v = 2'b11; n = 0;
    tick(); data_req = 1; data_wr = 1; data_addr = 32'h404; data_wdata = 32'h1; data_wstrb = 4'h1; #1;
    tick(); data_req = 0;
    while (data_data_ok_m !== 1 && n < 20) begin tick(); n++; end
    checks++;
    if (data_data_ok_m !== 1 || data_err !== 1) begin
      fails++; $display("FAIL err_write got=%b%b exp=11", data_data_ok_m, data_err);
    end
    bresp_v = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    r_en = 0; rd_data_v = 32'h0000_1111;
    tick(); inst_req = 1; inst_addr = 32'h1C00_0008; #1;
    tick(); inst_req = 0;
    while (rready !== 1 && n < 10) begin tick(); n++; end
    checks++;
    if (rready !== 1) begin
      fails++; $display("FAIL rst_mid_reach got=%b exp=1", rready);
    end
    reset = 1; #1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_valid_f, data_data_ok_m, data_err, inst_rdata_f, data_rdata_m} !== 72'b0) begin
      fails++; $display("FAIL rst_mid_clear got=%b/%h/%h exp=0", {arvalid, rready, awvalid, wvalid, bready, inst_valid_f, data_data_ok_m, data_err}, inst_rdata_f, data_rdata_m);
    end
    inst_req = 1; #1;
    checks++;
    if (inst_addr_ok !== 0) begin
      fails++; $display("FAIL rst_mid_nogrant got=%b exp=0", inst_addr_ok);
    end
    tick(); reset = 0; r_en = 1; rd_data_v = 32'h0280_0004; #1;
    checks++;
    if (inst_addr_ok !== 1) begin
      fails++; $display("FAIL rst_mid_grant got=%b exp=1", inst_addr_ok);
    end
    tick(); inst_req = 0;
    checks++;
    if (arvalid !== 1 || araddr !== 32'h1C00_0008) begin
      fails++; $display("FAIL rst_mid_ar got=%b/%h exp=1/1c000008", arvalid, araddr);
    end
    tick(); tick();
    checks++;
    if (inst_valid_f !== 1 || inst_rdata_f !== 32'h0280_0004) begin
      fails++; $display("FAIL rst_mid_data got=%b/%h exp=1/02800004", inst_valid_f, inst_rdata_f);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_collision();
    test_starve();
    test_error();
    test_reset_mid();
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
